// File: rtl/eth_pkt_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkt_parser_if
// Brief    : Receive-side word stream, egress write port and statistics of
//            the ingress packet parser.
// Revision : 1.0  initial release
// ============================================================================
interface eth_pkt_parser_if #(
    parameter int DW     = 32,
    parameter int NPORTS = 2,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_sop;
    logic              in_eop;
    logic [DW-1:0]     in_data;
    logic              out_afull;
    logic              out_wr_en;
    logic [DW+1:0]     out_data;
    logic [NPORTS-1:0] out_port_sel;
    logic              pkt_err;
    logic [CNT_W-1:0]  fwd_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    // Source / environment side
    modport master (
        output in_valid, in_sop, in_eop, in_data, out_afull,
        input  out_wr_en, out_data, out_port_sel, pkt_err, fwd_cnt, drop_cnt
    );

    // Parser side
    modport slave (
        input  in_valid, in_sop, in_eop, in_data, out_afull,
        output out_wr_en, out_data, out_port_sel, pkt_err, fwd_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/eth_pkt_parser.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkt_parser
// Brief    : Ingress packet parser: SOP/EOP delineation, destination lookup,
//            one-hot egress select, malformed-packet drop and statistics.
// Revision : 1.0  initial release
// ============================================================================
module eth_pkt_parser #(
    parameter int                         DW         = 32,
    parameter int                         NPORTS     = 2,
    parameter int                         ADDR_W     = 16,
    parameter logic [NPORTS*ADDR_W-1:0]   PORT_ADDRS = {16'hBEEF, 16'hABCD},
    parameter logic [ADDR_W-1:0]          BCAST_ADDR = 16'hFFFF,
    parameter int                         MAX_WORDS  = 64,
    parameter int                         CNT_W      = 16
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    eth_pkt_parser_if.slave bus
);
    localparam int                 c_LEN_W   = $clog2(MAX_WORDS + 1);
    localparam logic [c_LEN_W-1:0] c_LEN_ONE = c_LEN_W'(1);
    localparam logic [c_LEN_W-1:0] c_LEN_MAX = c_LEN_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SRC  = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_DROP = 2'd3;

    logic [1:0]         r_state,   w_stateNext;
    logic [c_LEN_W-1:0] r_count,   w_countNext;
    logic [c_LEN_W-1:0] w_countInc;
    logic               r_wrEn,    w_wrEn;
    logic [DW+1:0]      r_outData, w_outData;
    logic [NPORTS-1:0]  r_portSel, w_portSel;
    logic               r_pktErr,  w_pktErr;
    logic [CNT_W-1:0]   r_fwdCnt;
    logic [CNT_W-1:0]   r_dropCnt;
    logic               w_fwdInc;
    logic               w_dropInc;

    logic [ADDR_W-1:0]  w_dest;
    logic [NPORTS-1:0]  w_hit;
    logic               w_bcast;
    logic               w_hitAny;
    logic [NPORTS-1:0]  w_sel;

    assign w_dest = bus.in_data[ADDR_W-1:0];

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_addrCmp
            assign w_hit[gi] = (w_dest == PORT_ADDRS[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    assign w_bcast    = (w_dest == BCAST_ADDR);
    assign w_hitAny   = (|w_hit) | w_bcast;
    assign w_sel      = w_bcast ? {NPORTS{1'b1}} : w_hit;
    assign w_countInc = r_count + c_LEN_ONE;

    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        w_wrEn      = 1'b0;
        w_outData   = r_outData;
        w_portSel   = r_portSel;
        w_pktErr    = 1'b0;
        w_fwdInc    = 1'b0;
        w_dropInc   = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                c_ST_IDLE, c_ST_DROP: begin
                    // DROP recovers on any sop exactly as IDLE would
                    if (bus.in_sop) begin
                        if (bus.in_eop) begin
                            w_pktErr    = 1'b1;
                            w_dropInc   = 1'b1;
                            w_stateNext = c_ST_IDLE;
                        end else if (w_hitAny && !bus.out_afull) begin
                            w_wrEn      = 1'b1;
                            w_outData   = {1'b0, 1'b1, bus.in_data};
                            w_portSel   = w_sel;
                            w_countNext = c_LEN_ONE;
                            w_stateNext = c_ST_SRC;
                        end else begin
                            w_dropInc   = 1'b1;
                            w_stateNext = c_ST_DROP;
                        end
                    end else if (r_state == c_ST_IDLE) begin
                        w_pktErr = 1'b1;
                    end else if (bus.in_eop) begin
                        w_stateNext = c_ST_IDLE;
                    end
                end
                c_ST_SRC, c_ST_DATA: begin
                    w_wrEn = 1'b1;
                    if (bus.in_sop) begin
                        w_outData   = {1'b1, 1'b0, bus.in_data};
                        w_pktErr    = 1'b1;
                        w_dropInc   = 1'b1;
                        w_stateNext = c_ST_DROP;
                    end else begin
                        w_countNext = w_countInc;
                        if (bus.in_eop) begin
                            w_outData   = {1'b1, 1'b0, bus.in_data};
                            w_stateNext = c_ST_IDLE;
                            if (r_state == c_ST_SRC) begin
                                w_pktErr  = 1'b1;
                                w_dropInc = 1'b1;
                            end else begin
                                w_fwdInc = 1'b1;
                            end
                        end else if (w_countInc == c_LEN_MAX) begin
                            w_outData   = {1'b1, 1'b0, bus.in_data};
                            w_pktErr    = 1'b1;
                            w_dropInc   = 1'b1;
                            w_stateNext = c_ST_DROP;
                        end else begin
                            w_outData   = {1'b0, 1'b0, bus.in_data};
                            w_stateNext = c_ST_DATA;
                        end
                    end
                end
                default: w_stateNext = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= c_ST_IDLE;
            r_count   <= '0;
            r_wrEn    <= 1'b0;
            r_outData <= '0;
            r_portSel <= '0;
            r_pktErr  <= 1'b0;
            r_fwdCnt  <= '0;
            r_dropCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_count   <= w_countNext;
            r_wrEn    <= w_wrEn;
            r_outData <= w_outData;
            r_portSel <= w_portSel;
            r_pktErr  <= w_pktErr;
            if (w_fwdInc && (r_fwdCnt != {CNT_W{1'b1}})) begin
                r_fwdCnt <= r_fwdCnt + c_CNT_ONE;
            end
            if (w_dropInc && (r_dropCnt != {CNT_W{1'b1}})) begin
                r_dropCnt <= r_dropCnt + c_CNT_ONE;
            end
        end
    end

    assign bus.out_wr_en    = r_wrEn;
    assign bus.out_data     = r_outData;
    assign bus.out_port_sel = r_portSel;
    assign bus.pkt_err      = r_pktErr;
    assign bus.fwd_cnt      = r_fwdCnt;
    assign bus.drop_cnt     = r_dropCnt;
endmodule
`default_nettype wire
